tt_rebot449_alu_arbiter: RTL and testbench

//  Two-requester round-robin arbiter/sequencer for the shared combinational simple ALU.
//  - Accepts {op, data} requests over valid/ready.
//  - Drives the ALU's instruction/data inputs from registers.
//  - Captures the ALU result and returns it over a valid/ready response channel.
//  - Sits between the pad-level top and the ALU instance, so two sources can share one ALU.

---
 rtl/tt_rebot449_alu_arbiter_if.sv | 24 ++
 rtl/tt_rebot449_alu_arbiter.sv | 130 +++++++++++++
 tb/tb_tt_rebot449_alu_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tt_rebot449_alu_arbiter_if.sv
// Request/response channel between two requesters and the ALU arbiter.
// The master modport is the requester side; slave is the arbiter.
interface tt_rebot449_alu_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 3
) ();
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*OP_W-1:0]   req_op;
  logic [2*DATA_W-1:0] req_data;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_data;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/tt_rebot449_alu_arbiter.sv
// Two-requester round-robin sequencer in front of a shared combinational ALU.
// Optional per-requester response counters are built when ALU_ARB_STATS_EN is defined.
module tt_rebot449_alu_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 3
`ifdef ALU_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W  = 8
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  tt_rebot449_alu_arbiter_if.slave   bus,
  output logic [7:0]                 alu_instruction,
  output logic [DATA_W-1:0]          alu_data,
  input  logic [DATA_W-1:0]          alu_result,
  output logic                       busy
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           stat_cnt0,
  output logic [CNT_W-1:0]           stat_cnt1
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_grant_q, last_grant_d;
  logic [7:0]          instr_q, instr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic                sel;
  logic [OP_W-1:0]     sel_op;
  logic [DATA_W-1:0]   sel_data;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    sel      = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
    sel_op   = sel ? bus.req_op[2*OP_W-1:OP_W] : bus.req_op[OP_W-1:0];
    sel_data = sel ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_grant_d  = last_grant_q;
    instr_d       = instr_q;
    data_d        = data_q;
    rsp_data_d    = rsp_data_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          bus.req_ready[sel] = 1'b1;
          gnt_d              = sel;
          last_grant_d       = sel;
          instr_d            = 8'(sel_op);
          data_d             = sel_data;
          state_d            = StExec;
        end
      end
      StExec: begin
        rsp_data_d = alu_result;
        state_d    = StResp;
      end
      StResp: begin
        bus.rsp_valid[gnt_q] = 1'b1;
        if (bus.rsp_ready[gnt_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      instr_q      <= '0;
      data_q       <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      instr_q      <= instr_d;
      data_q       <= data_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign alu_instruction = instr_q;
  assign alu_data        = data_q;
  assign bus.rsp_data    = rsp_data_q;
  assign busy            = (state_q != StIdle);

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic             stat_hs;

  assign stat_hs = (state_q == StResp) && bus.rsp_ready[gnt_q];

  // Clear has priority over a same-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (stat_clr) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (stat_hs) begin
      if (gnt_q) begin
        cnt1_q <= cnt1_q + CNT_W'(1);
      end else begin
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_tt_rebot449_alu_arbiter.sv
// Randomized bench for tt_rebot449_alu_arbiter against a transaction-level reference model.
module tb_tt_rebot449_alu_arbiter;

  localparam int unsigned NumCycles = 6000;

  logic       clk;
  logic       rst_n;
  logic [7:0] alu_instruction;
  logic [7:0] alu_data;
  logic [7:0] alu_result;
  logic       busy;
`ifdef ALU_ARB_STATS_EN
  logic       stat_clr;
  logic [7:0] stat_cnt0;
  logic [7:0] stat_cnt1;
`endif

  tt_rebot449_alu_arbiter_if #(.DATA_W(8), .OP_W(3)) bus ();

  tt_rebot449_alu_arbiter #(
    .DATA_W(8),
    .OP_W  (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .alu_instruction(alu_instruction),
    .alu_data       (alu_data),
    .alu_result     (alu_result),
    .busy           (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_cnt0      (stat_cnt0),
    .stat_cnt1      (stat_cnt1)
`endif
  );

  // Behavioural stand-in for the shared ALU; ops 6/7 give zero.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] d);
    logic [7:0] hi, lo;
    hi = {4'b0, d[7:4]};
    lo = {4'b0, d[3:0]};
    case (op)
      3'd0:    alu_f = hi & lo;
      3'd1:    alu_f = hi | lo;
      3'd2:    alu_f = hi ^ lo;
      3'd3:    alu_f = ~d;
      3'd4:    alu_f = hi + lo;
      3'd5:    alu_f = lo - hi;
      default: alu_f = 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_instruction[2:0], alu_data);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, with its age in cycles since acceptance.
  bit         busy_m;
  int         age;
  int         gnt_m;
  int         last_m;
  logic [7:0] exp_instr;
  logic [7:0] exp_data;
  logic [7:0] exp_res;
  int         cnt_m [2];

  task automatic model_reset();
    busy_m    = 1'b0;
    age       = 0;
    gnt_m     = 0;
    last_m    = 1;
    exp_instr = 8'h00;
    exp_data  = 8'h00;
    exp_res   = 8'h00;
    cnt_m[0]  = 0;
    cnt_m[1]  = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_rsp_valid"}, bus.rsp_valid, 2'b00);
    check({pfx, "_rsp_data"}, bus.rsp_data, 8'h00);
    check({pfx, "_alu_instruction"}, alu_instruction, 8'h00);
    check({pfx, "_alu_data"}, alu_data, 8'h00);
`ifdef ALU_ARB_STATS_EN
    check({pfx, "_stat_cnt0"}, stat_cnt0, 8'h00);
    check({pfx, "_stat_cnt1"}, stat_cnt1, 8'h00);
`endif
  endtask

  // Called away from the rising edge: checks outputs, then advances the model across one edge.
  task automatic step(output logic [1:0] acc);
    logic [1:0] exp_ready;
    logic [1:0] exp_rv;
    logic [1:0] hs;
    logic       clr;
    int         g;
    exp_ready = 2'b00;
    exp_rv    = 2'b00;
    if (!busy_m) begin
      if (bus.req_valid == 2'b11) exp_ready = (last_m == 1) ? 2'b01 : 2'b10;
      else                        exp_ready = bus.req_valid;
    end else if (age >= 2) begin
      exp_rv = (gnt_m == 1) ? 2'b10 : 2'b01;
    end
    check("req_ready", bus.req_ready, exp_ready);
    check("rsp_valid", bus.rsp_valid, exp_rv);
    check("busy", busy, busy_m);
    if (exp_rv != 2'b00) check("rsp_data", bus.rsp_data, exp_res);
    check("alu_instruction", alu_instruction, exp_instr);
    check("alu_data", alu_data, exp_data);
`ifdef ALU_ARB_STATS_EN
    check("stat_cnt0", stat_cnt0, cnt_m[0] % 256);
    check("stat_cnt1", stat_cnt1, cnt_m[1] % 256);
    clr = stat_clr;
`else
    clr = 1'b0;
`endif
    acc = exp_ready & bus.req_valid;
    hs  = exp_rv & bus.rsp_ready;
    @(posedge clk);
    if (!busy_m) begin
      if (acc != 2'b00) begin
        g         = acc[1] ? 1 : 0;
        busy_m    = 1'b1;
        age       = 1;
        gnt_m     = g;
        last_m    = g;
        exp_instr = {5'b0, bus.req_op[g*3 +: 3]};
        exp_data  = bus.req_data[g*8 +: 8];
        exp_res   = alu_f(exp_instr[2:0], exp_data);
      end
    end else if (age == 1) begin
      age = 2;
    end else if (hs != 2'b00) begin
      busy_m = 1'b0;
      cnt_m[gnt_m]++;
    end
    if (clr) begin
      cnt_m[0] = 0;
      cnt_m[1] = 0;
    end
    #1;
  endtask

  // New random requests where the slot is free or just accepted; occasional drops.
  task automatic drive(input logic [1:0] acc);
    for (int n = 0; n < 2; n++) begin
      if (acc[n] || !bus.req_valid[n]) begin
        bus.req_valid[n]       = ($urandom_range(0, 9) < 5);
        bus.req_op[n*3 +: 3]   = 3'($urandom_range(0, 7));
        bus.req_data[n*8 +: 8] = 8'($urandom_range(0, 255));
      end else if ($urandom_range(0, 15) == 0) begin
        bus.req_valid[n] = 1'b0;
      end
    end
    bus.rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
`ifdef ALU_ARB_STATS_EN
    stat_clr = ($urandom_range(0, 63) == 0);
`endif
  endtask

  // Asynchronous reset pulse between edges, wherever the transaction happens to be.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  logic [1:0] acc;

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_op    = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 2'b00;
`ifdef ALU_ARB_STATS_EN
    stat_clr      = 1'b0;
`endif
    model_reset();
    #12;
    check_reset_outputs("reset");
    check("reset_req_ready", bus.req_ready, 2'b00);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: req0 op=4 data=0x35 -> 0x08 two edges after acceptance.
    bus.req_valid     = 2'b01;
    bus.req_op[2:0]   = 3'd4;
    bus.req_data[7:0] = 8'h35;
    bus.rsp_ready     = 2'b01;
    @(negedge clk);
    step(acc);
    bus.req_valid = 2'b00;
    check("t1_alu_instruction", alu_instruction, 8'h04);
    @(negedge clk);
    step(acc);
    @(negedge clk);
    check("t1_rsp_valid", bus.rsp_valid, 2'b01);
    check("t1_rsp_data", bus.rsp_data, 8'h08);
    step(acc);
    @(negedge clk);
    check("t1_idle", busy, 1'b0);
    step(acc);

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(negedge clk);
      if (cyc > 20 && $urandom_range(0, 199) == 0) pulse_reset();
      step(acc);
      drive(acc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
